// File: rtl/sd_img_pkg.sv
// Shared types and constants for the SD image sequencer: FSM states, step
// requests, default sector-address table and wrap-around index helpers.
package sd_img_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_READ  = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_NEXT = 2'd1,
    REQ_PREV = 2'd2
  } step_req_e;

  localparam int unsigned MAX_PICS        = 16;
  localparam int unsigned SECTORS_PER_PIC = 1200;

  // Images packed back to back on the card, image k at sector k*1200.
  function automatic logic [MAX_PICS*32-1:0] default_addr_tbl();
    logic [MAX_PICS*32-1:0] tbl;
    tbl = '0;
    for (int k = 0; k < MAX_PICS; k++) begin
      tbl[32*k +: 32] = 32'(k) * 32'(SECTORS_PER_PIC);
    end
    return tbl;
  endfunction

  localparam logic [MAX_PICS*32-1:0] DEF_PIC_ADDR_TBL = default_addr_tbl();

  function automatic logic [3:0] idx_next(input logic [3:0] idx, input int unsigned num);
    return (32'(idx) == num - 1) ? 4'd0 : idx + 4'd1;
  endfunction

  function automatic logic [3:0] idx_prev(input logic [3:0] idx, input int unsigned num);
    return (idx == 4'd0) ? 4'(num - 1) : idx - 4'd1;
  endfunction

endpackage

// File: rtl/sd_step_sel.sv
// Pending step-request latch plus the wrapped next/previous image index.
module sd_step_sel
  import sd_img_pkg::*;
#(
  parameter int unsigned PIC_NUM = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       next_i,
  input  logic       prev_i,
  input  logic       latch_en_i,
  input  logic       consume_i,
  input  logic [3:0] idx_i,
  output logic       req_vld_o,
  output logic [3:0] idx_req_o,
  output logic [3:0] idx_auto_o
);

  step_req_e pend_q;
  step_req_e new_req;
  step_req_e eff_req;

  // Simultaneous next and prev cancel out and leave any pending request alone.
  always_comb begin
    new_req = REQ_NONE;
    if (next_i && !prev_i) begin
      new_req = REQ_NEXT;
    end else if (prev_i && !next_i) begin
      new_req = REQ_PREV;
    end
    eff_req = (new_req != REQ_NONE) ? new_req : pend_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= REQ_NONE;
    end else if (consume_i) begin
      pend_q <= REQ_NONE;
    end else if (latch_en_i && (new_req != REQ_NONE)) begin
      pend_q <= new_req;
    end
  end

  assign req_vld_o  = (eff_req != REQ_NONE);
  assign idx_req_o  = (eff_req == REQ_PREV) ? idx_prev(idx_i, PIC_NUM) : idx_next(idx_i, PIC_NUM);
  assign idx_auto_o = idx_next(idx_i, PIC_NUM);

endmodule

// File: rtl/sd_img_seq_ctrl.sv
// Sequences sector reads of a table of images from an SD card, holding each
// image for a fixed delay (auto) or until a step request (manual).
module sd_img_seq_ctrl
  import sd_img_pkg::*;
#(
  parameter int unsigned                    PIC_NUM      = 16,
  parameter logic [MAX_PICS*32-1:0]         PIC_ADDR_TBL = DEF_PIC_ADDR_TBL,
  parameter int unsigned                    RD_NUM       = 1200,
  parameter int unsigned                    DELAY_CYC    = 130_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_busy,
  input  logic        mode,
  input  logic        next_pic,
  input  logic        prev_pic,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  output logic [3:0]  pic_idx,
  output logic        pic_done
);

  localparam logic [15:0] SEC_LAST = 16'(RD_NUM - 1);
  localparam logic [31:0] DLY_LAST = 32'(DELAY_CYC - 1);

  state_e      state_q;
  logic        b0_q, b1_q;
  logic        start_q, done_q;
  logic [31:0] addr_q;
  logic [31:0] dly_q;
  logic [15:0] sec_q;
  logic [3:0]  idx_q;

  logic        busy_fall;
  logic        req_vld;
  logic        consume;
  logic [3:0]  idx_req;
  logic [3:0]  idx_auto;
  logic [31:0] tbl_addr;

  assign busy_fall = b1_q & ~b0_q;
  assign consume   = (state_q == ST_HOLD) && req_vld;
  assign tbl_addr  = PIC_ADDR_TBL[{idx_q, 5'd0} +: 32];

  sd_step_sel #(
    .PIC_NUM (PIC_NUM)
  ) u_step_sel (
    .clk_i      (clk),
    .rst_ni     (rst),
    .next_i     (next_pic),
    .prev_i     (prev_pic),
    .latch_en_i (state_q != ST_HOLD),
    .consume_i  (consume),
    .idx_i      (idx_q),
    .req_vld_o  (req_vld),
    .idx_req_o  (idx_req),
    .idx_auto_o (idx_auto)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_START;
      b0_q    <= 1'b0;
      b1_q    <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      dly_q   <= '0;
      sec_q   <= '0;
      idx_q   <= '0;
    end else begin
      b0_q    <= rd_busy;
      b1_q    <= b0_q;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_START: begin
          addr_q  <= tbl_addr;
          sec_q   <= '0;
          start_q <= 1'b1;
          state_q <= ST_READ;
        end
        ST_READ: begin
          if (busy_fall) begin
            addr_q <= addr_q + 32'd1;
            sec_q  <= sec_q + 16'd1;
            if (sec_q == SEC_LAST) begin
              done_q  <= 1'b1;
              dly_q   <= '0;
              state_q <= ST_HOLD;
            end else begin
              start_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // An explicit step always wins over the automatic advance and its delay.
          if (req_vld) begin
            idx_q   <= idx_req;
            state_q <= ST_START;
          end else if (!mode) begin
            if (dly_q == DLY_LAST) begin
              idx_q   <= idx_auto;
              state_q <= ST_START;
            end else begin
              dly_q <= dly_q + 32'd1;
            end
          end
        end
        default: state_q <= ST_START;
      endcase
    end
  end

  assign rd_start_en = start_q;
  assign rd_sec_addr = addr_q;
  assign pic_idx     = idx_q;
  assign pic_done    = done_q;

endmodule

// File: tb/tb_sd_img_seq_ctrl.sv
// Bench for sd_img_seq_ctrl: directed scenarios plus randomized stepping,
// checked every cycle against an in-bench model of the sequencing rules.
module tb_sd_img_seq_ctrl;

  localparam int PN  = 3;
  localparam int RD  = 4;
  localparam int DLY = 10;
  localparam logic [511:0] TBL = {416'd0, 32'd300, 32'd200, 32'd100};

  int base_a [3] = '{100, 200, 300};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_busy = 1'b0;
  logic        mode = 1'b0;
  logic        next_pic = 1'b0;
  logic        prev_pic = 1'b0;
  logic        rd_start_en;
  logic        pic_done;
  logic [31:0] rd_sec_addr;
  logic [3:0]  pic_idx;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int st_addr[$];
  int st_idx[$];
  int st_cyc[$];
  int dn_cyc[$];

  bit tog_en    = 1'b0;
  bit rand_busy = 1'b0;
  int bz_cnt    = 0;

  // model state
  bit          m_start_pend;
  bit          m_reading;
  bit          e_start;
  bit          e_done;
  bit          bz1, bz2;
  logic [31:0] m_addr;
  int          m_idx, m_nsec, m_hold_t, m_req;

  always #5 clk = ~clk;

  sd_img_seq_ctrl #(
    .PIC_NUM      (PN),
    .PIC_ADDR_TBL (TBL),
    .RD_NUM       (RD),
    .DELAY_CYC    (DLY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_busy     (rd_busy),
    .mode        (mode),
    .next_pic    (next_pic),
    .prev_pic    (prev_pic),
    .rd_start_en (rd_start_en),
    .rd_sec_addr (rd_sec_addr),
    .pic_idx     (pic_idx),
    .pic_done    (pic_done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: an image is a run of RD sector reads; a sector is done two
  // cycles after busy falls; between images the hold rules pick the next one.
  initial forever begin : model
    int s, r;
    bit fell;
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_start_pend = 1'b1; m_reading = 1'b0; m_idx = 0; m_addr = '0;
      m_nsec = 0; m_hold_t = 0; m_req = 0; bz1 = 1'b0; bz2 = 1'b0;
      e_start = 1'b0; e_done = 1'b0;
    end else begin
      fell = bz2 && !bz1;
      s = (next_pic && !prev_pic) ? 1 : ((prev_pic && !next_pic) ? -1 : 0);
      e_start = 1'b0;
      e_done  = 1'b0;
      if (m_start_pend) begin
        m_addr = 32'(base_a[m_idx]);
        m_nsec = 0;
        e_start = 1'b1;
        m_start_pend = 1'b0;
        m_reading = 1'b1;
        if (s != 0) m_req = s;
      end else if (m_reading) begin
        if (s != 0) m_req = s;
        if (fell) begin
          m_addr = m_addr + 32'd1;
          m_nsec++;
          if (m_nsec == RD) begin
            e_done = 1'b1;
            m_reading = 1'b0;
            m_hold_t = 0;
          end else begin
            e_start = 1'b1;
          end
        end
      end else begin
        r = (s != 0) ? s : m_req;
        if (r != 0) begin
          m_idx = (m_idx + r + PN) % PN;
          m_req = 0;
          m_start_pend = 1'b1;
        end else if (!mode) begin
          m_hold_t++;
          if (m_hold_t == DLY) begin
            m_idx = (m_idx + 1) % PN;
            m_start_pend = 1'b1;
          end
        end
      end
      bz2 = bz1;
      bz1 = rd_busy;
    end
  end

  initial forever begin : compare
    @(posedge clk);
    #1;
    cyc++;
    check("rd_start_en", 32'(rd_start_en), 32'(e_start));
    check("pic_done",    32'(pic_done),    32'(e_done));
    check("rd_sec_addr", rd_sec_addr,      m_addr);
    check("pic_idx",     32'(pic_idx),     32'(m_idx));
    if (rd_start_en) begin
      st_addr.push_back(int'(rd_sec_addr));
      st_idx.push_back(int'(pic_idx));
      st_cyc.push_back(cyc);
    end
    if (pic_done) dn_cyc.push_back(cyc);
  end

  // SD engine stand-in: busy for a few cycles after every start pulse.
  initial forever begin : busy_drv
    @(negedge clk);
    if (rd_start_en) bz_cnt = rand_busy ? $urandom_range(1, 6) : 5;
    if (tog_en) begin
      rd_busy = 1'($urandom_range(0, 1));
    end else begin
      rd_busy = (bz_cnt > 0);
      if (bz_cnt > 0) bz_cnt--;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_starts(input int n, input int lim);
    int k = 0;
    while (st_addr.size() < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (st_addr.size() < n) check("start_timeout", 32'(st_addr.size()), 32'(n));
  endtask

  task automatic wait_dones(input int n, input int lim);
    int k = 0;
    while (dn_cyc.size() < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (dn_cyc.size() < n) check("done_timeout", 32'(dn_cyc.size()), 32'(n));
  endtask

  task automatic pulse(input bit n, input bit p);
    next_pic = n;
    prev_pic = p;
    @(negedge clk);
    next_pic = 1'b0;
    prev_pic = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    st_addr.delete(); st_idx.delete(); st_cyc.delete(); dn_cyc.delete();
    rst = 1'b1;
  endtask

  initial begin : stim
    int ea [13] = '{100, 101, 102, 103, 200, 201, 202, 203, 300, 301, 302, 303, 100};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_start", 32'(rd_start_en), 32'd0);
    check("rst_addr",  rd_sec_addr,      32'd0);
    check("rst_idx",   32'(pic_idx),     32'd0);
    check("rst_done",  32'(pic_done),    32'd0);

    // auto cycling through all images and back to the first
    rst = 1'b1;
    @(negedge clk);
    check("first_start", 32'(rd_start_en), 32'd1);
    check("first_addr",  rd_sec_addr,      32'd100);
    wait_starts(13, 600);
    for (int i = 0; i < 13; i++) begin
      check("auto_addr", 32'(st_addr[i]), 32'(ea[i]));
      check("auto_idx",  32'(st_idx[i]),  32'((i / 4) % 3));
    end
    check("auto_gap", 32'(st_cyc[4] - dn_cyc[0]), 32'd11);

    // step request during image 0 skips the delay
    do_reset();
    wait_starts(3, 100);
    pulse(1'b1, 1'b0);
    wait_starts(5, 100);
    check("skip_addr", 32'(st_addr[4]), 32'd200);
    check("skip_idx",  32'(st_idx[4]),  32'd1);
    check("skip_gap",  32'(st_cyc[4] - dn_cyc[0]), 32'd2);

    // manual mode: hold with busy noise, then next, prev, prev, then both
    do_reset();
    wait_dones(1, 100);
    mode = 1'b1;
    tog_en = 1'b1;
    repeat (50) @(negedge clk);
    tog_en = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_nstart", 32'(st_addr.size()), 32'd4);
    check("hold_addr",   rd_sec_addr,         32'd104);
    check("hold_idx",    32'(pic_idx),        32'd0);
    pulse(1'b1, 1'b0);
    wait_starts(5, 20);
    check("man_next", 32'(st_addr[4]), 32'd200);
    wait_dones(2, 100);
    pulse(1'b0, 1'b1);
    wait_starts(9, 20);
    check("man_prev1", 32'(st_addr[8]), 32'd100);
    wait_dones(3, 100);
    pulse(1'b0, 1'b1);
    wait_starts(13, 20);
    check("man_prev2",     32'(st_addr[12]), 32'd300);
    check("man_prev2_idx", 32'(st_idx[12]),  32'd2);
    wait_dones(4, 100);
    repeat (2) @(negedge clk);
    pulse(1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("both_nstart", 32'(st_addr.size()), 32'd16);
    check("both_idx",    32'(pic_idx),        32'd2);

    // reset in the middle of image 1
    mode = 1'b0;
    do_reset();
    wait_starts(7, 200);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_addr",  rd_sec_addr,      32'd0);
    check("midrst_idx",   32'(pic_idx),     32'd0);
    check("midrst_start", 32'(rd_start_en), 32'd0);
    repeat (3) @(negedge clk);
    st_addr.delete(); st_idx.delete(); st_cyc.delete(); dn_cyc.delete();
    rst = 1'b1;
    @(negedge clk);
    check("rel_start", 32'(rd_start_en), 32'd1);
    check("rel_addr",  rd_sec_addr,      32'd100);
    check("rel_idx",   32'(pic_idx),     32'd0);

    // randomized modes, steps, busy lengths and the odd reset
    rand_busy = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      int p;
      if ($urandom_range(0, 39) == 0) mode = 1'($urandom_range(0, 1));
      p = $urandom_range(0, 29);
      next_pic = (p == 0) || (p == 2);
      prev_pic = (p == 1) || (p == 2);
      if ($urandom_range(0, 1499) == 0) rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end
    next_pic = 1'b0;
    prev_pic = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
